// File: rtl/i2c_slave_reg_bank_if.sv
// Byte-level link between the I2C slave engine and the register bank, plus the host read port.
// The engine and host side use the master modport; the register bank uses the slave modport.
interface i2c_slave_reg_bank_if #(
  parameter int unsigned PTR_W = 4
) ();
  logic             txn_start;
  logic             txn_rw;
  logic             txn_stop;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             tx_taken;
  logic [7:0]       tx_data;
  logic             wr_strobe;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             ptr_err;
  logic             busy;
  logic [PTR_W-1:0] host_rd_addr;
  logic [7:0]       host_rd_data;

  modport master (
    output txn_start, txn_rw, txn_stop, rx_valid, rx_data, tx_taken, host_rd_addr,
    input  tx_data, wr_strobe, wr_addr, wr_data, ptr_err, busy, host_rd_data
  );

  modport slave (
    input  txn_start, txn_rw, txn_stop, rx_valid, rx_data, tx_taken, host_rd_addr,
    output tx_data, wr_strobe, wr_addr, wr_data, ptr_err, busy, host_rd_data
  );
endinterface

// File: rtl/i2c_slave_reg_bank.sv
// I2C register bank: the first byte of a write sets the pointer, later bytes write sequential
// registers; reads stream regs[ptr] with auto-increment. Register 0 is a read-only device ID.
module i2c_slave_reg_bank #(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned PTR_W     = 4,
  parameter logic [7:0]  DEVICE_ID = 8'hA5
) (
  input logic                clk,
  input logic                reset,
  i2c_slave_reg_bank_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWaitPtr, StWrData, StRdData} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [7:0]       r_regs [NUM_REGS];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_next;
  logic [PTR_W-1:0] w_ptr_inc;
  logic             r_ptr_err;
  logic             w_ptr_err_next;
  logic             w_wr_en;
  logic [7:0]       r_tx_data;
  logic             r_wr_strobe;
  logic [PTR_W-1:0] r_wr_addr;
  logic [7:0]       r_wr_data;
  logic             w_rx_ptr_ok;

  assign w_ptr_inc   = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + PTR_W'(1);
  assign w_rx_ptr_ok = 32'(bus.rx_data) < NUM_REGS;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // txn_start outranks txn_stop so a repeated START opens the new transaction.
  always_comb begin
    w_state_next = r_state;
    if (bus.txn_start) begin
      w_state_next = bus.txn_rw ? StRdData : StWaitPtr;
    end else if (bus.txn_stop) begin
      w_state_next = StIdle;
    end else if (r_state == StWaitPtr && bus.rx_valid) begin
      w_state_next = StWrData;
    end
  end

  always_comb begin
    w_ptr_next     = r_ptr;
    w_ptr_err_next = r_ptr_err;
    w_wr_en        = 1'b0;
    if (bus.txn_start) begin
      w_ptr_err_next = 1'b0;
    end else if (!bus.txn_stop) begin
      unique case (r_state)
        StWaitPtr: begin
          if (bus.rx_valid) begin
            if (w_rx_ptr_ok) w_ptr_next = bus.rx_data[PTR_W-1:0];
            else             w_ptr_err_next = 1'b1;
          end
        end
        StWrData: begin
          // Bytes after a bad pointer are dropped; register 0 swallows the byte but still advances.
          if (bus.rx_valid && !r_ptr_err) begin
            w_wr_en    = (r_ptr != '0);
            w_ptr_next = w_ptr_inc;
          end
        end
        StRdData: begin
          if (bus.tx_taken) w_ptr_next = w_ptr_inc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_ptr_err   <= 1'b0;
      r_tx_data   <= DEVICE_ID;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'h00;
    end else begin
      r_ptr       <= w_ptr_next;
      r_ptr_err   <= w_ptr_err_next;
      r_tx_data   <= r_regs[r_ptr];
      r_wr_strobe <= w_wr_en;
      if (w_wr_en) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= bus.rx_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= (i == 0) ? DEVICE_ID : 8'h00;
      end
    end else if (w_wr_en) begin
      r_regs[r_ptr] <= bus.rx_data;
    end
  end

  assign bus.tx_data      = r_tx_data;
  assign bus.wr_strobe    = r_wr_strobe;
  assign bus.wr_addr      = r_wr_addr;
  assign bus.wr_data      = r_wr_data;
  assign bus.ptr_err      = r_ptr_err;
  assign bus.busy         = (r_state != StIdle);
  assign bus.host_rd_data = (32'(bus.host_rd_addr) < NUM_REGS) ? r_regs[bus.host_rd_addr] : 8'h00;

endmodule

// File: tb/tb_i2c_slave_reg_bank.sv
// Directed bench for i2c_slave_reg_bank: expected register writes are queued as bytes are driven
// and matched against wr_strobe; tx_data, ptr_err, busy and host reads are checked inline.
module tb_i2c_slave_reg_bank;
  localparam int unsigned NumRegs = 16;
  localparam int unsigned PtrW    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2c_slave_reg_bank_if #(.PTR_W(PtrW)) bus ();

  i2c_slave_reg_bank #(
    .NUM_REGS  (NumRegs),
    .PTR_W     (PtrW),
    .DEVICE_ID (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [PtrW+7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (bus.wr_strobe === 1'b1) begin
      chk("wr_strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("wr_addr_data", 32'({bus.wr_addr, bus.wr_data}), 32'(exp_q.pop_front()));
    end
  end

  task automatic drive(input logic st, input logic rw, input logic sp, input logic rv,
                       input logic [7:0] rd, input logic tk);
    @(negedge clk);
    bus.txn_start = st;
    bus.txn_rw    = rw;
    bus.txn_stop  = sp;
    bus.rx_valid  = rv;
    bus.rx_data   = rd;
    bus.tx_taken  = tk;
  endtask

  task automatic idle();       drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0); endtask
  task automatic start_w();    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0); endtask
  task automatic start_r();    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0); endtask
  task automatic stop();       drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0); endtask
  task automatic taken();      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1); endtask
  task automatic rx(input logic [7:0] d); drive(1'b0, 1'b0, 1'b0, 1'b1, d, 1'b0); endtask

  task automatic rx_wr(input logic [7:0] d, input logic [PtrW-1:0] a);
    rx(d);
    exp_q.push_back({a, d});
  endtask

  task automatic host_chk(input string tag, input logic [PtrW-1:0] a, input logic [7:0] exp);
    bus.host_rd_addr = a;
    #1;
    chk(tag, 32'(bus.host_rd_data), 32'(exp));
  endtask

  task automatic tx_chk(input string tag, input logic [7:0] exp);
    chk(tag, 32'(bus.tx_data), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.txn_start = 1'b0; bus.txn_rw = 1'b0; bus.txn_stop = 1'b0; bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;  bus.tx_taken = 1'b0; bus.host_rd_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_tx_data", 32'(bus.tx_data), 32'hA5);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ptr_err", 32'(bus.ptr_err), 0);
    chk("rst_wr_strobe", 32'(bus.wr_strobe), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_wr_data", 32'(bus.wr_data), 0);
    host_chk("rst_reg0", 4'd0, 8'hA5);
    host_chk("rst_reg3", 4'd3, 8'h00);

    // Pointer then two data bytes.
    start_w(); rx(8'h03); rx_wr(8'h11, 4'd3); rx_wr(8'h22, 4'd4);
    idle();
    chk("wr_busy", 32'(bus.busy), 1);
    stop(); idle();
    chk("wr_idle", 32'(bus.busy), 0);
    host_chk("wr_reg3", 4'd3, 8'h11);
    host_chk("wr_reg4", 4'd4, 8'h22);
    tx_chk("wr_ptr5_track", 8'h00);

    // Pointer-only write, then read stream with auto-increment.
    start_w(); rx(8'h03); stop(); start_r(); idle(); idle();
    tx_chk("rd_reg3", 8'h11);
    taken(); idle(); idle();
    tx_chk("rd_reg4", 8'h22);
    taken(); idle(); idle();
    tx_chk("rd_reg5", 8'h00);
    stop();

    // Wrap from 15 to 0; register 0 stays read-only.
    start_w(); rx(8'h01); rx_wr(8'h5C, 4'd1); stop();
    start_w(); rx(8'h0F); rx_wr(8'hAA, 4'd15); rx(8'hBB); stop(); idle();
    host_chk("wrap_reg15", 4'd15, 8'hAA);
    host_chk("wrap_reg0", 4'd0, 8'hA5);
    start_r(); idle(); idle();
    tx_chk("wrap_ptr1", 8'h5C);
    stop();
    start_w(); rx(8'h00); stop(); start_r(); idle(); idle();
    tx_chk("rd_reg0_id", 8'hA5);
    taken(); idle(); idle();
    tx_chk("rd_after_reg0", 8'h5C);
    stop();

    // Out-of-range pointer: sticky error, data dropped, pointer kept at 1.
    start_w(); rx(8'h20); idle();
    chk("bad_ptr_err", 32'(bus.ptr_err), 1);
    rx(8'h77); rx(8'h88); idle();
    chk("bad_ptr_sticky", 32'(bus.ptr_err), 1);
    host_chk("bad_no_write", 4'd1, 8'h5C);
    stop(); idle();
    chk("bad_ptr_after_stop", 32'(bus.ptr_err), 1);
    start_r(); idle();
    chk("bad_ptr_cleared", 32'(bus.ptr_err), 0);
    idle();
    tx_chk("bad_ptr_kept", 8'h5C);
    stop();

    // Priority: txn_start drops a same-cycle byte; repeated START enters read.
    start_w(); rx(8'h0A); rx_wr(8'h66, 4'd10); rx_wr(8'h77, 4'd11); stop();
    start_w(); rx(8'h02);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0);
    rx(8'h09); rx_wr(8'h3C, 4'd9);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(); idle();
    chk("rstart_busy", 32'(bus.busy), 1);
    tx_chk("rstart_reg10", 8'h66);
    taken(); rx(8'h55); idle();
    tx_chk("rstart_reg11", 8'h77);
    host_chk("prio_reg2_untouched", 4'd2, 8'h00);
    host_chk("prio_reg9", 4'd9, 8'h3C);
    stop(); idle();
    chk("prio_idle", 32'(bus.busy), 0);

    // Reset in the middle of a write transaction.
    start_w(); rx(8'h05); rx_wr(8'h99, 4'd5); idle();
    host_chk("mid_reg5", 4'd5, 8'h99);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_tx", 32'(bus.tx_data), 32'hA5);
    host_chk("mid_rst_reg5", 4'd5, 8'h00);
    host_chk("mid_rst_reg15", 4'd15, 8'h00);
    host_chk("mid_rst_reg0", 4'd0, 8'hA5);
    rx(8'h42); idle();
    @(negedge clk);
    reset = 1'b0;
    rx(8'h42); idle(); idle();
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_strobe", 32'(bus.wr_strobe), 0);
    tx_chk("post_rst_ptr0", 8'hA5);
    host_chk("post_rst_reg5", 4'd5, 8'h00);

    idle();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
